clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl_pkg.sv | 17 +
 rtl/clk_gate_ctrl_if.sv | 13 +
 rtl/clk_gate_dom_fsm.sv | 83 ++++++++
 rtl/clk_gate_ctrl.sv | 73 +++++++
 4 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default constants for the clock-gate controller.
package clk_gate_ctrl_pkg;

  // Per-domain gating state.
  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } dom_state_e;

  localparam int DEF_NUM_DOM  = 4;
  localparam int DEF_IDLE_CYC = 16;
  localparam int DEF_WAKE_CYC = 2;
  localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity inputs and gate-control outputs of the clock-gate controller.
interface clk_gate_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic               force_on_i;
  logic [NUM_DOM-1:0] busy_i;
  logic [NUM_DOM-1:0] wake_req_i;
  logic [NUM_DOM-1:0] clkEn_o;
  logic [NUM_DOM-1:0] ready_o;

  modport master (output force_on_i, busy_i, wake_req_i, input clkEn_o, ready_o);
  modport slave  (input force_on_i, busy_i, wake_req_i, output clkEn_o, ready_o);
endinterface

// File: rtl/clk_gate_dom_fsm.sv
// One domain's gating FSM and idle/wake counter. Outputs are flops so the
// external latch-based gater never sees a combinational glitch.
module clk_gate_dom_fsm
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYC = DEF_IDLE_CYC,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic force_on,
  input  logic busy,
  input  logic wake_req,
  input  logic grant,
  output logic cand,
  output logic clk_en,
  output logic ready
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  dom_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             act;

  assign act  = busy | wake_req | force_on;
  // Only a gated domain with pending activity competes for a wake slot.
  assign cand = (state == ST_OFF) & act;

  // State, counter and registered outputs; outputs only change together
  // with the state so clk_en/ready always reflect the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_ON;
      cnt    <= '0;
      clk_en <= 1'b1;
      ready  <= 1'b1;
    end else begin
      case (state)
        ST_ON: begin
          if (!act) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end
        end
        ST_DRAIN: begin
          if (act) begin
            state <= ST_ON;
          end else if (cnt == IDLE_LAST) begin
            state  <= ST_OFF;
            clk_en <= 1'b0;
            ready  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (grant) begin
            state  <= ST_WAKE;
            cnt    <= '0;
            clk_en <= 1'b1;
          end
        end
        ST_WAKE: begin
          // Inputs are ignored here: a wake, once started, always completes.
          cnt <= cnt + CNT_W'(1);
          if (cnt == WAKE_LAST) begin
            state <= ST_ON;
            ready <= 1'b1;
          end
        end
        default: begin
          state  <= ST_ON;
          clk_en <= 1'b1;
          ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: NUM_DOM independent domain FSMs plus a round-robin
// arbiter that lets at most one domain start waking per cycle.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int NUM_DOM  = DEF_NUM_DOM,
  parameter int IDLE_CYC = DEF_IDLE_CYC,
  parameter int WAKE_CYC = DEF_WAKE_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset_n,
  clk_gate_ctrl_if.slave bus
);

  localparam int PW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  logic [NUM_DOM-1:0] cand;
  logic [NUM_DOM-1:0] grant;
  logic [NUM_DOM-1:0] clk_en;
  logic [NUM_DOM-1:0] ready;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_vld;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    clk_gate_dom_fsm #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC),
      .CNT_W    (CNT_W)
    ) u_dom (
      .clk      (clk),
      .reset_n  (reset_n),
      .force_on (bus.force_on_i),
      .busy     (bus.busy_i[g]),
      .wake_req (bus.wake_req_i[g]),
      .grant    (grant[g]),
      .cand     (cand[g]),
      .clk_en   (clk_en[g]),
      .ready    (ready[g])
    );
  end

  assign bus.clkEn_o = clk_en;
  assign bus.ready_o = ready;

  // Round-robin pick: first candidate at or after ptr, wrapping.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_DOM; k++) begin
      idx = (int'(ptr) + k) % NUM_DOM;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // Pointer moves past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == PW'(NUM_DOM - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule
